// File: rtl/i2c_master_byte_writer.sv
// Single-byte I2C write master: START, address+W, one data byte, STOP, with ACK checks.
// Define I2C_RETRY_EN to re-issue NACKed transactions up to RETRY_MAX extra times.
module i2c_master_byte_writer #(
  parameter int         CLK_DIV   = 4,
  parameter logic [6:0] I2C_ADR   = 7'h27,
  parameter int         RETRY_MAX = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [7:0] wr_data,
  output logic       busy,
  output logic       done,
  output logic       nack,
  inout  wire        SDA,
  output logic       SCL
);

`ifdef I2C_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  localparam int            QW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [QW-1:0] QLAST = QW'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ACK_A, DATA, ACK_D, STOP, DONE_PULSE, GAP
  } state_t;

  state_t        state;
  logic [QW-1:0] qcnt;
  logic [1:0]    q;
  logic [2:0]    bitcnt;
  logic [7:0]    retry_cnt;
  logic [7:0]    shreg;
  logic [7:0]    data_reg;
  logic          sda_low;
  logic          scl_low;
  logic          sda_smp;
  logic          nack_flag;
  logic          tick;
  logic          retry_now;

  assign tick      = (qcnt == QLAST);
  assign retry_now = RETRY_EN && nack_flag && (retry_cnt < 8'(RETRY_MAX));
  assign SDA       = sda_low ? 1'b0 : 1'bz;
  assign SCL       = scl_low ? 1'b0 : 1'bz;

  // Bus outputs are registered for the quarter being entered, so they change on quarter edges only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      qcnt      <= '0;
      q         <= '0;
      bitcnt    <= '0;
      retry_cnt <= '0;
      sda_low   <= 1'b0;
      scl_low   <= 1'b0;
      sda_smp   <= 1'b0;
      nack_flag <= 1'b0;
      wr_ready  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      nack      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state inside {START, ADDR, ACK_A, DATA, ACK_D, STOP, GAP}) begin
        qcnt <= tick ? '0 : qcnt + QW'(1);
        if (tick) q <= q + 2'd1;
      end
      if (tick && q == 2'd2) sda_smp <= SDA;

      case (state)
        IDLE: if (wr_valid) begin
          state     <= START;
          wr_ready  <= 1'b0;
          busy      <= 1'b1;
          retry_cnt <= '0;
          nack_flag <= 1'b0;
        end
        START: if (tick) begin
          if (q == 2'd1) sda_low <= 1'b1;
          else if (q == 2'd3) begin
            state   <= ADDR;
            bitcnt  <= 3'd7;
            scl_low <= 1'b1;
            sda_low <= ~shreg[7];
          end
        end
        ADDR, DATA: if (tick) begin
          if (q == 2'd1) scl_low <= 1'b0;
          else if (q == 2'd3) begin
            scl_low <= 1'b1;
            bitcnt  <= bitcnt - 3'd1;
            if (bitcnt == 3'd0) begin
              state   <= (state == ADDR) ? ACK_A : ACK_D;
              sda_low <= 1'b0;
            end else begin
              sda_low <= ~shreg[6];
            end
          end
        end
        ACK_A, ACK_D: if (tick) begin
          if (q == 2'd1) scl_low <= 1'b0;
          else if (q == 2'd3) begin
            scl_low <= 1'b1;
            if (state == ACK_A && !sda_smp) begin
              state   <= DATA;
              sda_low <= ~data_reg[7];
            end else begin
              state     <= STOP;
              sda_low   <= 1'b1;
              nack_flag <= sda_smp;
            end
          end
        end
        STOP: if (tick) begin
          if (q == 2'd1) scl_low <= 1'b0;
          else if (q == 2'd2) sda_low <= 1'b0;
          else if (q == 2'd3) begin
            state <= DONE_PULSE;
            // A retried attempt finishes silently; only the final outcome is reported
            if (!retry_now) begin
              done <= 1'b1;
              nack <= nack_flag;
            end
          end
        end
        DONE_PULSE: state <= GAP;
        GAP: if (tick && q == 2'd3) begin
          if (retry_now) begin
            state     <= START;
            retry_cnt <= retry_cnt + 8'd1;
            nack_flag <= 1'b0;
          end else begin
            state    <= IDLE;
            wr_ready <= 1'b1;
            busy     <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Shift register feeds the bit for the next quarter-0; reloaded with the address on each START
  always_ff @(posedge clk) begin
    if (state == IDLE && wr_valid) begin
      data_reg <= wr_data;
      shreg    <= {I2C_ADR, 1'b0};
    end else if (state == GAP && tick && q == 2'd3) begin
      shreg <= {I2C_ADR, 1'b0};
    end else if (tick && q == 2'd3) begin
      if (state == ACK_A) shreg <= data_reg;
      else if (state == ADDR || state == DATA) shreg <= shreg << 1;
    end
  end

endmodule

// File: tb/tb_i2c_master_byte_writer.sv
// Bench: two masters (address 7'h27 and 7'h28) share one pulled-up bus with an 8-bit I/O slave model at 7'h27.
module tb_i2c_master_byte_writer;

  localparam logic [6:0] SLV_ADR = 7'h27;
`ifdef I2C_RETRY_EN
  localparam int LAT_B = 562;
  localparam int ATT_B = 3;
`else
  localparam int LAT_B = 176;
  localparam int ATT_B = 1;
`endif

  typedef struct {
    bit         sel;
    logic       nack;
    logic [7:0] io;
    int         lat;
    int         rises;
    int         attempts;
    int         hs;
    int         starts0;
  } exp_t;

  logic       clk;
  logic       rst = 1'b1;
  logic       valid_a = 1'b0, valid_b = 1'b0;
  logic [7:0] data_a = 8'h00, data_b = 8'h00;
  logic       ready_a, ready_b, busy_a, busy_b, done_a, done_b, nack_a, nack_b;
  wire        sda_w;
  wire        scl_w;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   mon_busy = 1'b0;
  exp_t sb[$];

  // slave model state
  logic       prev_scl = 1'b1, prev_sda = 1'b1;
  logic       s_ack = 1'b0;
  logic [7:0] s_shift = 8'h00;
  logic [7:0] io_out = 8'h00;
  int         s_bit = 0, s_phase = 0;  // 0 idle, 1 address, 2 data, 3 ignore
  int         start_cnt = 0, rises = 0, last_rises = 0;

  pullup (sda_w);
  pullup (scl_w);
  assign sda_w = s_ack ? 1'b0 : 1'bz;

  i2c_master_byte_writer #(.CLK_DIV(4), .I2C_ADR(7'h27), .RETRY_MAX(2)) dut_a (
    .clk(clk), .rst(rst), .wr_valid(valid_a), .wr_ready(ready_a), .wr_data(data_a),
    .busy(busy_a), .done(done_a), .nack(nack_a), .SDA(sda_w), .SCL(scl_w));

  i2c_master_byte_writer #(.CLK_DIV(4), .I2C_ADR(7'h28), .RETRY_MAX(2)) dut_b (
    .clk(clk), .rst(rst), .wr_valid(valid_b), .wr_ready(ready_b), .wr_data(data_b),
    .busy(busy_b), .done(done_b), .nack(nack_b), .SDA(sda_w), .SCL(scl_w));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Slave samples the bus on the falling clk edge, away from master updates
  always @(negedge clk) begin
    prev_scl <= scl_w;
    prev_sda <= sda_w;
    if (prev_scl && scl_w && prev_sda && !sda_w) begin
      s_phase <= 1; s_bit <= 0; s_ack <= 1'b0; rises <= 0;
      start_cnt <= start_cnt + 1;
    end else if (prev_scl && scl_w && !prev_sda && sda_w) begin
      s_phase <= 0; s_ack <= 1'b0; last_rises <= rises;
    end else if (!prev_scl && scl_w) begin
      rises <= rises + 1;
      if (s_bit < 8) s_shift <= {s_shift[6:0], sda_w};
      s_bit <= s_bit + 1;
    end else if (prev_scl && !scl_w) begin
      if (s_bit == 8) begin
        if (s_phase == 1 && s_shift == {SLV_ADR, 1'b0}) s_ack <= 1'b1;
        else if (s_phase == 2) begin s_ack <= 1'b1; io_out <= s_shift; end
        else s_phase <= 3;
      end else if (s_bit == 9) begin
        s_ack <= 1'b0; s_bit <= 0;
        s_phase <= (s_phase == 1) ? 2 : 3;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic write_byte(input bit sel, input logic [7:0] d, input bit hold, input bit push,
                            input logic exp_nack, input logic [7:0] exp_io, input int exp_lat,
                            input int exp_rises, input int exp_att, output int hs);
    exp_t e;
    int n;
    n = 0;
    hs = -1;
    if (sel) begin valid_b = 1'b1; data_b = d; end
    else     begin valid_a = 1'b1; data_a = d; end
    while (!(sel ? ready_b : ready_a) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n >= 3000) begin
      n_fail++;
      $display("FAIL handshake_timeout: wr_ready stayed 0 for %0d cycles, required 1", n);
      valid_a = 1'b0; valid_b = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    hs = cyc;
    if (push) begin
      e.sel = sel; e.nack = exp_nack; e.io = exp_io; e.lat = exp_lat;
      e.rises = exp_rises; e.attempts = exp_att; e.hs = hs; e.starts0 = start_cnt;
      sb.push_back(e);
    end
    if (!hold) begin
      @(negedge clk);
      if (sel) valid_b = 1'b0; else valid_a = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(sb.size() == 0 && !mon_busy && ready_a && ready_b) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n >= 5000) begin
      n_fail++;
      $display("FAIL idle_timeout: %0d responses outstanding, required 0", sb.size());
    end
  endtask

  // Monitor: pops the expected response whenever a master pulses done
  initial begin : monitor
    exp_t e;
    bit   sel;
    forever begin
      @(negedge clk);
      if (done_a || done_b) begin
        mon_busy = 1'b1;
        sel = done_b;
        if (sb.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_done: got done from master %0d, required none", sel);
        end else begin
          e = sb.pop_front();
          check("done_source", int'(sel), int'(e.sel));
          check("nack_at_done", int'(sel ? nack_b : nack_a), int'(e.nack));
          check("done_latency", cyc - e.hs, e.lat);
          check("slave_ioout", int'(io_out), int'(e.io));
          check("scl_clocks_last_attempt", last_rises, e.rises);
          check("bus_attempts", start_cnt - e.starts0, e.attempts);
          @(negedge clk);
          check("done_width", int'(sel ? done_b : done_a), 0);
          repeat (15) @(negedge clk);
          check("ready_early", int'(sel ? ready_b : ready_a), 0);
          @(negedge clk);
          check("ready_return", int'(sel ? ready_b : ready_a), 1);
          check("nack_held", int'(sel ? nack_b : nack_a), int'(e.nack));
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int hs1, hs2;
    repeat (3) @(negedge clk);
    check("rst_ready", int'(ready_a), 1);
    check("rst_busy", int'(busy_a), 0);
    check("rst_done", int'(done_a), 0);
    check("rst_nack", int'(nack_a), 0);
    check("rst_scl", int'(scl_w), 1);
    check("rst_sda", int'(sda_w), 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 8'hA5 to the matching address: 9+9 bit clocks plus the STOP clock
    write_byte(1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 8'hA5, 320, 19, 1, hs1);
    wait_idle();

    // wrong address: address bits + ACK clock + STOP clock, slave untouched
    write_byte(1'b1, 8'h3C, 1'b0, 1'b1, 1'b1, 8'hA5, LAT_B, 10, ATT_B, hs1);
    wait_idle();

    // back-to-back with wr_valid held: second accepted 320+1+16+1 cycles later
    write_byte(1'b0, 8'h01, 1'b1, 1'b1, 1'b0, 8'h01, 320, 19, 1, hs1);
    write_byte(1'b0, 8'hFE, 1'b0, 1'b1, 1'b0, 8'hFE, 320, 19, 1, hs2);
    check("b2b_handshake_gap", hs2 - hs1, 338);
    wait_idle();

    // reset in the middle of DATA bit 3 (bits start at 160 + 16*k cycles)
    write_byte(1'b0, 8'hC3, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0, 0, hs1);
    repeat (226) @(negedge clk);
    check("pre_rst_busy", int'(busy_a), 1);
    rst = 1'b1;
    #1;
    check("midrst_scl", int'(scl_w), 1);
    check("midrst_sda", int'(sda_w), 1);
    check("midrst_ready", int'(ready_a), 1);
    check("midrst_busy", int'(busy_a), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("midrst_ioout", int'(io_out), 8'hFE);
    @(negedge clk);

    write_byte(1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, 8'h5A, 320, 19, 1, hs1);
    wait_idle();

    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_master_byte_writer.md
Name: i2c_master_byte_writer

Overview:
- Single-byte I2C write master that drives the SDA/SCL bus of the 8-bit I/O slave expander (default address 7'h27).
- Accepts one byte per valid/ready handshake from on-chip logic and generates START, address+W, data byte, and STOP, checking the slave ACK after each byte.
- Reports completion and NACK status.
- Sits directly upstream of the slave; SDA and SCL are open-drain (drive 0 or release to z, external pull-ups).

Parameters:
- CLK_DIV, 4: clk cycles per SCL quarter-period (>=2); SCL bit period = 4*CLK_DIV clk cycles.
- I2C_ADR, 7'h27: 7-bit target slave address.
- RETRY_MAX, 3: extra attempts after NACK; used only with I2C_RETRY_EN.

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  asynchronous, active-high reset.
- wr_valid  input  1  byte request valid.
- wr_ready  output  1  block idle and able to accept a byte.
- wr_data  input  8  byte to write; captured on handshake.
- busy  output  1  transaction in progress (includes bus-free gap).
- done  output  1  one-cycle pulse at end of transaction.
- nack  output  1  status of last transaction; valid from the done pulse, held until next done.
- SDA  inout  1  I2C data, open-drain.
- SCL  output  1  I2C clock, open-drain (0 or z).

Behaviour:
- Reset (async, rst=1): state IDLE, SDA=z, SCL=z, wr_ready=1, busy=0, done=0, nack=0, all counters 0.
- Reset mid-transaction: same values immediately. No STOP is generated; the next transaction's START re-synchronises the slave.
- Handshake: accept when wr_valid & wr_ready at a rising clk edge. Latch wr_data. wr_ready=0 and busy=1 from the next cycle.
- Quarter timer counts 0..CLK_DIV-1. A 2-bit quarter index q0..q3 advances on timer wrap.
- Data bit timing:
  - q0,q1: SCL=0; SDA set at start of q0.
  - q2,q3: SCL=z.
  - SDA sampled (registered) at the last clk of q2.
- States:
  - IDLE → START on handshake.
  - START, 4 quarters: q0,q1 SDA=z SCL=z; q2,q3 SDA=0 SCL=z.
  - ADDR: 8 bits, MSB first: I2C_ADR[6:0] then 0 (W).
  - ACK_A: 1 bit, SDA=z, sample. 0 → DATA; 1 → STOP with nack flag set.
  - DATA: 8 bits, wr_data[7] first.
  - ACK_D: 1 bit, sample; 1 sets nack flag. → STOP.
  - STOP, 4 quarters: q0,q1 SCL=0 SDA=0; q2 SCL=z SDA=0; q3 SCL=z SDA=z.
  - DONE_PULSE: one cycle; done=1, nack=flag. → GAP.
  - GAP: 4*CLK_DIV cycles bus-free, busy=1. → IDLE.
- Latency:
  - ACK transaction: handshake edge to done = 80*CLK_DIV cycles (START 4 + 9 bits×4 + 9 bits×4 + STOP 4 quarters).
  - Address NACK: 44*CLK_DIV cycles.
  - wr_ready returns 1 exactly 4*CLK_DIV+1 cycles after done.
- Bit counter: 3 bits, counts 7 down to 0. Wrap from 0 moves to the ACK state.
- wr_valid while busy is ignored; no queueing.
- SCL is never stretched-checked; slave clock stretching is not supported.

Optional Feature:
- Macro: I2C_RETRY_EN.
- Defined:
  - On NACK (address or data), after GAP the block re-issues the full transaction (START onward) with the same latched byte, up to RETRY_MAX times.
  - done pulses only once: on first ACK'd completion (nack=0) or after the final failed attempt (nack=1).
  - busy stays 1 throughout.
- Undefined: no retry. Every transaction ends with exactly one done pulse, and RETRY_MAX is ignored.

Test Plan:
- Bench: CLK_DIV=4, DUT wired to the 8-bit I/O slave (address 7'h27) with pull-ups.
- Write 8'hA5 → slave IOout=8'hA5; done pulses 320 cycles after handshake; nack=0; wr_ready=1 at 337 cycles.
- I2C_ADR=7'h28 against slave at 7'h27, write 8'h3C → nack=1 at done, 176 cycles after handshake; IOout unchanged; no DATA bits on bus.
- Back-to-back writes 8'h01 then 8'hFE, wr_valid held high → two START/STOP pairs separated by ≥16 idle-high cycles; IOout ends 8'hFE; second byte accepted only when wr_ready=1.
- Assert rst during DATA bit 3 → SDA=z, SCL=z, wr_ready=1 same cycle; following write of 8'h5A completes with nack=0 and IOout=8'h5A.
- I2C_RETRY_EN, RETRY_MAX=2, wrong address → 3 full attempts on bus, single done with nack=1; with the correct address, single attempt, nack=0.
